bcd_counter_ndigit: RTL and testbench
=====================================

# bcd_counter_ndigit

Parametrised N-digit BCD up/down counter with a built-in tick prescaler, synchronous parallel load, and a selectable wrap or saturate mode. It supersedes the fixed 3-digit up-only counter. It runs entirely in the `clk` domain and advances on a one-cycle clock-enable strobe, not on a derived clock. It feeds the display/time-keeping datapath: seven-segment decoders, stopwatch and timer control.

## Interface
- `DIGITS`, default 3: number of BCD digits; must be at least 1.
- `PRESCALE`, default 50: `clk` cycles per count step; must be at least 1; 50000000 gives 1 s at 50 MHz.
- `clk`  in  1  system clock, rising edge.
- `areset_n`  in  1  reset, asynchronous and active-low; one clock.
- `enable`  in  1  count enable, sampled on tick cycles.
- `up`  in  1  direction: 1 counts up, 0 counts down.
- `sat`  in  1  mode: 1 saturates at the limits, 0 wraps around.
- `load`  in  1  synchronous parallel load strobe.
- `load_val`  in  4*DIGITS  load value; digit k sits at bits [4k+3:4k].
- `count`  out  4*DIGITS  counter value, same digit packing as `load_val`.
- `tick`  out  1  prescaler strobe, high for one cycle per period.
- `at_max`  out  1  every digit equals 9.
- `at_zero`  out  1  every digit equals 0.
- `wrap`  out  1  one-cycle pulse: the counter wrapped on the last update.

## Operation
- Prescaler:
  - Register `p` has width `max(1, $clog2(PRESCALE))`.
  - `p` counts 0 to PRESCALE-1, then returns to 0.
  - It is free-running: `enable` and `load` do not affect it.
  - `tick = (p == PRESCALE-1)`, decoded from the register, so it is glitch-free.
  - With PRESCALE=1, `tick` is high in every cycle.
- Priority at each rising edge: `load` > (`tick` && `enable`) step > hold.
- Load:
  - `count` takes `load_val`.
  - Any digit above 9 is clamped to 9; other digits are unaffected.
  - `wrap` is driven to 0 in that cycle.
  - A load in the same cycle as a tick suppresses that step.
- Up step: ripple-carry BCD increment.
  - Digit 0 goes +1. A digit at 9 becomes 0 and carries into the next digit.
- Down step: ripple-borrow BCD decrement.
  - A digit at 0 becomes 9 and borrows from the next digit.
- Boundary, up at all-9s:
  - `sat`=0: `count` goes to all-0s and `wrap` pulses.
  - `sat`=1: `count` holds and `wrap` stays 0.
- Boundary, down at all-0s:
  - `sat`=0: `count` goes to all-9s and `wrap` pulses.
  - `sat`=1: `count` holds and `wrap` stays 0.
- `up` and `sat` are sampled only at the step edge; changing them mid-period has no side effects.
- Illegal BCD digits cannot arise internally; load clamping guarantees this.

## Timing
- Reset values while `areset_n`=0: `p`=0, `count`=0, `wrap`=0, `tick`=0, `at_zero`=1, `at_max`=0.
  - With PRESCALE=1, `tick` is 1 even in reset.
- Reset asserted mid-period clears everything immediately, with no clock needed. Release is synchronous to the next rising edge.
- After release, `tick` first rises after PRESCALE-1 edges; the first count change lands on edge PRESCALE.
- Step latency: `count` updates on the rising edge at which `tick`=1 was sampled.
- `wrap` is registered and high for exactly the one cycle after the wrapping edge, aligned with the new `count`.
- Load latency: one edge; `count` equals the clamped `load_val` in the following cycle.
- `at_max` and `at_zero` are combinational decodes of the registered `count`, with zero latency relative to it.
- Worst-case logic depth is the DIGITS-long carry/borrow chain. DIGITS ≤ 8 must meet 50 MHz.

## Structure
- `bcd_pkg` holds:
  - typedef `bcd_digit_t` (4 bits);
  - constants `BCD_MAX` = 4'd9 and `BCD_MIN` = 4'd0;
  - functions `bcd_inc` and `bcd_dec` (digit + carry/borrow in, digit + carry/borrow out), shared with other BCD blocks.
- Sub-module `tick_gen #(PERIOD)` holds the prescaler. It drives `tick` and is reusable by other timed blocks.
- The top level uses a generate loop over DIGITS to chain `bcd_inc`/`bcd_dec`, then the mode mux and flag decode.

## Test plan
All scenarios use DIGITS=3 and PRESCALE=4 unless stated.
- Reset and prescaler:
  - Stimulus: hold `areset_n` low, release, `enable`=1, `up`=1.
  - Response: `count`=000 and `at_zero`=1 during reset; `tick` high every 4th cycle; `count`=001 after edge 4 and 002 after edge 8.
- Up wrap vs saturate:
  - Stimulus: load 998 with `sat`=0, `up`=1, then run 2 ticks.
  - Response: `count` goes 999 (`at_max`=1), then 000 with `wrap`=1 for 1 cycle.
  - Repeat with `sat`=1. Response: holds 999 and `wrap` never asserts.
- Down across digits:
  - Stimulus: load 100, `up`=0, `sat`=0, run 2 ticks.
  - Response: 099, then 098.
  - Stimulus: load 000 and run 1 tick. Response: 999 with a `wrap` pulse.
- Load priority and clamping:
  - Stimulus: assert `load` with `load_val`=0xA5F in a `tick` cycle, `enable`=1.
  - Response: `count`=959 next cycle and no step applied.
- Enable gating and async reset mid-period:
  - Stimulus: `enable`=0 across 3 ticks. Response: `count` unchanged.
  - Stimulus: drop `areset_n` with `p`=2 between edges. Response: `count`=000 and `p`=0 immediately; the next `tick` comes PRESCALE-1 edges after release.
- Parameter corners:
  - DIGITS=1, PRESCALE=1: counts 0–9 and wraps every 10 cycles, `wrap` on the 9→0 edge.
  - DIGITS=6: load 999999, step up, `wrap` asserts.

Source files
------------

// File: rtl/bcd_pkg.sv
// BCD helper package shared by the BCD blocks.
// Provides the digit type, digit limits, and single-digit increment,
// decrement and clamp functions used to build ripple carry/borrow chains.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    // Result of a single-digit step: new digit plus carry/borrow out.
    typedef struct packed {
        logic       carry;
        bcd_digit_t digit;
    } bcd_step_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    // Increment one digit when cin is set; 9 rolls to 0 with carry out.
    function automatic bcd_step_t bcd_inc(input bcd_digit_t digit, input logic cin);
        bcd_step_t res;
        res.carry = 1'b0;
        res.digit = digit;
        if (cin) begin
            if (digit >= BCD_MAX) begin
                res.carry = 1'b1;
                res.digit = BCD_MIN;
            end else begin
                res.digit = digit + 4'd1;
            end
        end else begin
            res.digit = digit;
        end
        return res;
    endfunction

    // Decrement one digit when bin is set; 0 rolls to 9 with borrow out.
    function automatic bcd_step_t bcd_dec(input bcd_digit_t digit, input logic bin);
        bcd_step_t res;
        res.carry = 1'b0;
        res.digit = digit;
        if (bin) begin
            if (digit == BCD_MIN) begin
                res.carry = 1'b1;
                res.digit = BCD_MAX;
            end else begin
                res.digit = digit - 4'd1;
            end
        end else begin
            res.digit = digit;
        end
        return res;
    endfunction

    // Force a possibly illegal nibble into the BCD range.
    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t digit);
        bcd_digit_t res;
        if (digit > BCD_MAX) begin
            res = BCD_MAX;
        end else begin
            res = digit;
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_counter_ndigit_tick_gen.sv
// Free-running prescaler producing a one-cycle strobe every PERIOD cycles.
// Ports:
//   clk      - system clock, rising edge
//   areset_n - asynchronous active-low reset
//   tick     - high while the phase register holds PERIOD-1
module tick_gen #(
    parameter int PERIOD = 50
) (
    input  logic clk,
    input  logic areset_n,
    output logic tick
);

    localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [W-1:0] LAST = W'(PERIOD - 1);

    logic [W-1:0] p_r;

    // Phase counter: 0 .. PERIOD-1, then back to 0.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            p_r <= '0;
        end else if (p_r == LAST) begin
            p_r <= '0;
        end else begin
            p_r <= p_r + W'(1);
        end
    end

    // Decoded straight from the register so the strobe is glitch-free;
    // with PERIOD=1 LAST is 0 and the strobe is constantly high.
    assign tick = (p_r == LAST);

endmodule

// File: rtl/bcd_counter_ndigit.sv
// N-digit BCD up/down counter with prescaled step strobe, synchronous
// parallel load (illegal digits clamped to 9) and wrap/saturate mode.
// Ports:
//   clk, areset_n  - clock and asynchronous active-low reset
//   enable         - step enable, sampled on tick cycles
//   up             - 1 counts up, 0 counts down
//   sat            - 1 saturates at the limits, 0 wraps
//   load, load_val - parallel load strobe and value (digit k at [4k+3:4k])
//   count          - registered counter value
//   tick           - prescaler strobe
//   at_max/at_zero - all digits 9 / all digits 0
//   wrap           - one-cycle pulse after a wrapping step
module bcd_counter_ndigit
    import bcd_pkg::*;
#(
    parameter int DIGITS   = 3,
    parameter int PRESCALE = 50
) (
    input  logic                  clk,
    input  logic                  areset_n,
    input  logic                  enable,
    input  logic                  up,
    input  logic                  sat,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tick,
    output logic                  at_max,
    output logic                  at_zero,
    output logic                  wrap
);

    localparam int CW = 4 * DIGITS;
    localparam logic [CW-1:0] ALL_NINES = {DIGITS{BCD_MAX}};

    logic [CW-1:0] count_r;
    logic [CW-1:0] next_count_s;
    logic [CW-1:0] inc_count_s;
    logic [CW-1:0] dec_count_s;
    logic [CW-1:0] load_clamped_s;
    logic [DIGITS:0] carry_s;
    logic [DIGITS:0] borrow_s;
    logic          wrap_r;
    logic          next_wrap_s;
    logic          tick_s;

    tick_gen #(
        .PERIOD (PRESCALE)
    ) u_tick_gen (
        .clk      (clk),
        .areset_n (areset_n),
        .tick     (tick_s)
    );

    // Digit 0 always receives the +1 / -1; the chain end flags a full-range
    // overflow (all 9s going up) or underflow (all 0s going down).
    assign carry_s[0]  = 1'b1;
    assign borrow_s[0] = 1'b1;

    generate
        for (genvar k = 0; k < DIGITS; k++) begin : g_digit
            bcd_step_t inc_s;
            bcd_step_t dec_s;

            assign inc_s = bcd_inc(count_r[4*k +: 4], carry_s[k]);
            assign dec_s = bcd_dec(count_r[4*k +: 4], borrow_s[k]);

            assign inc_count_s[4*k +: 4]    = inc_s.digit;
            assign dec_count_s[4*k +: 4]    = dec_s.digit;
            assign carry_s[k+1]             = inc_s.carry;
            assign borrow_s[k+1]            = dec_s.carry;
            assign load_clamped_s[4*k +: 4] = bcd_clamp(load_val[4*k +: 4]);
        end
    endgenerate

    // Next-state mux: load beats a step; a step at a limit either wraps
    // (pulsing wrap) or holds, depending on sat.
    always_comb begin
        next_count_s = count_r;
        next_wrap_s  = 1'b0;
        if (load) begin
            next_count_s = load_clamped_s;
        end else if (tick_s && enable) begin
            if (up) begin
                if (carry_s[DIGITS] && sat) begin
                    next_count_s = count_r;
                end else begin
                    next_count_s = inc_count_s;
                    next_wrap_s  = carry_s[DIGITS];
                end
            end else begin
                if (borrow_s[DIGITS] && sat) begin
                    next_count_s = count_r;
                end else begin
                    next_count_s = dec_count_s;
                    next_wrap_s  = borrow_s[DIGITS];
                end
            end
        end else begin
            next_count_s = count_r;
        end
    end

    // Counter value and wrap pulse registers.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            count_r <= '0;
            wrap_r  <= 1'b0;
        end else begin
            count_r <= next_count_s;
            wrap_r  <= next_wrap_s;
        end
    end

    assign count   = count_r;
    assign wrap    = wrap_r;
    assign tick    = tick_s;
    assign at_max  = (count_r == ALL_NINES);
    assign at_zero = (count_r == '0);

endmodule

// File: tb/tb_bcd_counter_ndigit.sv
// Self-checking bench: three counter instances (3 digits / prescale 4,
// 1 digit / prescale 1, 6 digits / prescale 4) compared every cycle
// against an integer-valued reference model, plus directed vectors.
module tb_bcd_counter_ndigit;

    logic        clk;
    logic        rst_n;
    logic [2:0]  en;
    logic [2:0]  upd;
    logic [2:0]  st;
    logic [2:0]  ld;
    logic [23:0] lv [3];
    logic [11:0] c0;
    logic [3:0]  c1;
    logic [23:0] c2;
    logic [2:0]  tk;
    logic [2:0]  wr;
    logic [2:0]  amx;
    logic [2:0]  azr;

    int checks;
    int failures;

    int     dig [3] = '{3, 1, 6};
    int     pre [3] = '{4, 1, 4};
    longint m_val [3];
    int     m_p [3];
    logic   m_wrap [3];
    int     steps0;

    bcd_counter_ndigit #(.DIGITS(3), .PRESCALE(4)) dut (
        .clk(clk), .areset_n(rst_n), .enable(en[0]), .up(upd[0]), .sat(st[0]),
        .load(ld[0]), .load_val(lv[0][11:0]), .count(c0), .tick(tk[0]),
        .at_max(amx[0]), .at_zero(azr[0]), .wrap(wr[0]));

    bcd_counter_ndigit #(.DIGITS(1), .PRESCALE(1)) dut1 (
        .clk(clk), .areset_n(rst_n), .enable(en[1]), .up(upd[1]), .sat(st[1]),
        .load(ld[1]), .load_val(lv[1][3:0]), .count(c1), .tick(tk[1]),
        .at_max(amx[1]), .at_zero(azr[1]), .wrap(wr[1]));

    bcd_counter_ndigit #(.DIGITS(6), .PRESCALE(4)) dut6 (
        .clk(clk), .areset_n(rst_n), .enable(en[2]), .up(upd[2]), .sat(st[2]),
        .load(ld[2]), .load_val(lv[2]), .count(c2), .tick(tk[2]),
        .at_max(amx[2]), .at_zero(azr[2]), .wrap(wr[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic longint maxv(input int d);
        longint v = 1;
        for (int k = 0; k < d; k++) v = v * 10;
        return v - 1;
    endfunction

    function automatic logic [23:0] to_bcd(input longint val, input int d);
        logic [23:0] r = '0;
        longint v = val;
        for (int k = 0; k < d; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic longint clamp_val(input logic [23:0] x, input int d);
        longint v = 0;
        longint w = 1;
        int dg;
        for (int k = 0; k < d; k++) begin
            dg = int'(x[4*k +: 4]);
            if (dg > 9) dg = 9;
            v = v + longint'(dg) * w;
            w = w * 10;
        end
        return v;
    endfunction

    function automatic logic [23:0] get_cnt(input int i);
        if (i == 0) return {12'd0, c0};
        else if (i == 1) return {20'd0, c1};
        else return c2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_val[i] = 0; m_p[i] = 0; m_wrap[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input int i);
        logic tnow;
        if (!rst_n) begin
            m_val[i] = 0; m_p[i] = 0; m_wrap[i] = 1'b0;
        end else begin
            tnow = (m_p[i] == pre[i] - 1);
            m_wrap[i] = 1'b0;
            if (ld[i]) begin
                m_val[i] = clamp_val(lv[i], dig[i]);
            end else if (tnow && en[i]) begin
                if (i == 0) steps0++;
                if (upd[i]) begin
                    if (m_val[i] == maxv(dig[i])) begin
                        if (!st[i]) begin m_val[i] = 0; m_wrap[i] = 1'b1; end
                    end else m_val[i] = m_val[i] + 1;
                end else begin
                    if (m_val[i] == 0) begin
                        if (!st[i]) begin m_val[i] = maxv(dig[i]); m_wrap[i] = 1'b1; end
                    end else m_val[i] = m_val[i] - 1;
                end
            end
            m_p[i] = (m_p[i] + 1) % pre[i];
        end
    endtask

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("count%0d", i), get_cnt(i), to_bcd(m_val[i], dig[i]));
            chk($sformatf("tick%0d", i), 24'(tk[i]), 24'(m_p[i] == pre[i] - 1));
            chk($sformatf("wrap%0d", i), 24'(wr[i]), 24'(m_wrap[i]));
            chk($sformatf("at_max%0d", i), 24'(amx[i]), 24'(m_val[i] == maxv(dig[i])));
            chk($sformatf("at_zero%0d", i), 24'(azr[i]), 24'(m_val[i] == 0));
        end
    endtask

    task automatic step();
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_edge(i);
        #1;
        check_all();
    endtask

    task automatic wait_tick(input int i);
        int n = 0;
        while (!tk[i] && n < 16) begin
            step();
            n++;
        end
        chk("wait_tick", 24'(tk[i]), 24'd1);
    endtask

    typedef struct {
        logic [11:0] lval;
        logic        dir_up;
        logic        satm;
        int          ticks;
        logic [11:0] exp_cnt;
        logic        exp_wrap;
    } vec_t;

    vec_t vecs [9];

    initial begin
        int n;
        int start;
        int wraps;
        logic wseen;

        checks = 0; failures = 0; steps0 = 0;
        vecs[0] = '{12'h998, 1'b1, 1'b0, 1, 12'h999, 1'b0};
        vecs[1] = '{12'h998, 1'b1, 1'b0, 2, 12'h000, 1'b1};
        vecs[2] = '{12'h998, 1'b1, 1'b1, 2, 12'h999, 1'b0};
        vecs[3] = '{12'h100, 1'b0, 1'b0, 2, 12'h098, 1'b0};
        vecs[4] = '{12'h000, 1'b0, 1'b0, 1, 12'h999, 1'b1};
        vecs[5] = '{12'h000, 1'b0, 1'b1, 1, 12'h000, 1'b0};
        vecs[6] = '{12'h0C9, 1'b1, 1'b0, 1, 12'h100, 1'b0};
        vecs[7] = '{12'h459, 1'b1, 1'b0, 3, 12'h462, 1'b0};
        vecs[8] = '{12'hFFF, 1'b0, 1'b1, 1, 12'h998, 1'b0};

        rst_n = 1'b0;
        en = 3'b000; upd = 3'b111; st = 3'b000; ld = 3'b000;
        for (int i = 0; i < 3; i++) lv[i] = '0;
        model_reset();

        // Reset state, no clock edge yet.
        #3;
        check_all();
        step();
        step();

        // Release, then first steps of the 3-digit counter.
        rst_n = 1'b1;
        en[0] = 1'b1;
        step(); step(); step();
        chk("first_tick", 24'(tk[0]), 24'd1);
        chk("before_first_step", {12'd0, c0}, 24'h000);
        step();
        chk("after_edge4", {12'd0, c0}, 24'h001);
        step(); step(); step(); step();
        chk("after_edge8", {12'd0, c0}, 24'h002);
        en[0] = 1'b0;

        // Table of load-then-run sequences.
        for (int v = 0; v < 9; v++) begin
            ld[0] = 1'b1; lv[0] = {12'd0, vecs[v].lval}; en[0] = 1'b0;
            step();
            ld[0] = 1'b0; en[0] = 1'b1;
            upd[0] = vecs[v].dir_up; st[0] = vecs[v].satm;
            start = steps0; wseen = 1'b0; n = 0;
            while ((steps0 - start) < vecs[v].ticks && n < 64) begin
                step();
                wseen = wseen | wr[0];
                n++;
            end
            en[0] = 1'b0;
            chk($sformatf("vec%0d_count", v), {12'd0, c0}, {12'd0, vecs[v].exp_cnt});
            chk($sformatf("vec%0d_wrap_seen", v), 24'(wseen), 24'(vecs[v].exp_wrap));
        end

        // Load in a tick cycle: clamped value, step suppressed.
        upd[0] = 1'b1; st[0] = 1'b0;
        wait_tick(0);
        ld[0] = 1'b1; lv[0] = 24'h000A5F; en[0] = 1'b1;
        step();
        chk("load_priority", {12'd0, c0}, 24'h959);
        ld[0] = 1'b0; en[0] = 1'b0;

        // Enable gating across three periods.
        repeat (12) step();
        chk("enable_gate", {12'd0, c0}, 24'h959);

        // Asynchronous reset with the prescaler at phase 2.
        ld[0] = 1'b1; lv[0] = 24'h000123;
        step();
        ld[0] = 1'b0;
        wait_tick(0);
        step(); step(); step();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("async_reset_count", {12'd0, c0}, 24'h000);
        chk("async_reset_tick", 24'(tk[0]), 24'd0);
        #1;
        rst_n = 1'b1;
        step(); step();
        chk("post_reset_no_tick", 24'(tk[0]), 24'd0);
        step();
        chk("post_reset_tick", 24'(tk[0]), 24'd1);

        // DIGITS=1, PRESCALE=1: wraps every 10 cycles.
        ld[1] = 1'b1; lv[1] = '0;
        step();
        ld[1] = 1'b0; en[1] = 1'b1; upd[1] = 1'b1; st[1] = 1'b0;
        wraps = 0;
        repeat (20) begin
            step();
            wraps = wraps + int'(wr[1]);
        end
        en[1] = 1'b0;
        chk("d1_wrap_count", 24'(wraps), 24'd2);
        chk("d1_count", {20'd0, c1}, 24'h0);

        // DIGITS=6: all nines stepping up wraps.
        ld[2] = 1'b1; lv[2] = 24'h999999;
        step();
        ld[2] = 1'b0; en[2] = 1'b1; upd[2] = 1'b1; st[2] = 1'b0;
        n = 0;
        while (!wr[2] && n < 16) begin
            step();
            n++;
        end
        en[2] = 1'b0;
        chk("d6_wrap", 24'(wr[2]), 24'd1);
        chk("d6_count", c2, 24'h000000);

        // Randomized traffic on all three instances.
        repeat (400) begin
            for (int i = 0; i < 3; i++) begin
                ld[i]  = ($urandom_range(0, 7) == 0);
                en[i]  = ($urandom_range(0, 3) != 0);
                upd[i] = 1'($urandom_range(0, 1));
                st[i]  = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 3))
                    0: lv[i] = 24'h999999;
                    1: lv[i] = 24'h000000;
                    default: lv[i] = 24'($urandom);
                endcase
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
